// File: rtl/matrix_mul_pkg.sv
// Shared widths and types for the matrix_mul partial-product multiplier.
package matrix_mul_pkg;

  localparam int MM_WIDTH = 4;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int MM_PROD_W = prod_width(MM_WIDTH);

  typedef logic [MM_WIDTH-1:0]  operand_t;
  typedef logic [MM_PROD_W-1:0] product_t;

endpackage

// File: rtl/matrix_mul_if.sv
// Operand/result bundle for matrix_mul. in_valid alone qualifies a and b;
// there is no ready, so the slave accepts every valid cycle (no backpressure).
interface matrix_mul_if
  import matrix_mul_pkg::*;
#(
  parameter int WIDTH = MM_WIDTH
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   result;

  modport master (output in_valid, a, b, input out_valid, result);
  modport slave  (input in_valid, a, b, output out_valid, result);
endinterface

// File: rtl/matrix_mul_full_adder.sv
// One-bit full adder; half-adder positions tie cin_i to zero.
module mm_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/matrix_mul.sv
// Unsigned WIDTHxWIDTH multiplier: AND-array partial products, carry-save
// reduction, final ripple-carry adder, one registered output stage.
module matrix_mul
  import matrix_mul_pkg::*;
#(
  parameter int WIDTH = MM_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  matrix_mul_if.slave  bus
);
  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0][PW-1:0] pp_row;
  logic [PW-1:0]            prod_d;
  logic [PW-1:0]            result_q;
  logic                     out_valid_q;

  genvar i, j;

  for (i = 0; i < WIDTH; i++) begin : g_pp
    assign pp_row[i] = {{WIDTH{1'b0}}, bus.a & {WIDTH{bus.b[i]}}} << i;
  end

  // Each stage folds one more row into a (sum, carry) pair; carry is kept
  // pre-shifted so the next stage can add it bit-aligned.
  for (i = 0; i < WIDTH; i++) begin : csa
    logic [PW-1:0] s_w;
    logic [PW-1:0] c_w;
    if (i == 0) begin : g_init
      assign s_w = pp_row[0];
      assign c_w = '0;
    end else begin : g_add
      assign c_w[0] = 1'b0;
      for (j = 0; j < PW - 1; j++) begin : g_bit
        mm_full_adder u_fa (
          .a_i   (csa[i-1].s_w[j]),
          .b_i   (csa[i-1].c_w[j]),
          .cin_i (pp_row[i][j]),
          .s_o   (s_w[j]),
          .cout_o(c_w[j+1])
        );
      end
      // Carry out of the MSB is always zero because the product fits in PW bits.
      assign s_w[PW-1] = csa[i-1].s_w[PW-1] ^ csa[i-1].c_w[PW-1] ^ pp_row[i][PW-1];
    end
  end

  for (j = 0; j < PW - 1; j++) begin : rca
    logic s_w;
    logic c_w;
    logic cin_w;
    if (j == 0) begin : g_cin0
      assign cin_w = 1'b0;
    end else begin : g_cinn
      assign cin_w = rca[j-1].c_w;
    end
    mm_full_adder u_fa (
      .a_i   (csa[WIDTH-1].s_w[j]),
      .b_i   (csa[WIDTH-1].c_w[j]),
      .cin_i (cin_w),
      .s_o   (s_w),
      .cout_o(c_w)
    );
    assign prod_d[j] = s_w;
  end

  assign prod_d[PW-1] = csa[WIDTH-1].s_w[PW-1] ^ csa[WIDTH-1].c_w[PW-1] ^ rca[PW-2].c_w;

  // The register only loads on in_valid, so X operands on idle cycles never reach result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= prod_d;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_mul.sv
// Directed bench for matrix_mul: reset, corner products, hold, reset in
// flight and an exhaustive back-to-back stream checked from an expected queue.
module tb_matrix_mul;
  import matrix_mul_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  matrix_mul_if #(.WIDTH(4)) bus ();

  matrix_mul #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    drive(1'b1, 4'd3, 4'd5);

    // A product before reset makes the asynchronous clear observable.
    @(negedge clk);
    check("pre_reset_res", 16'(bus.result), 16'd15);
    check("pre_reset_vld", 16'(bus.out_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res", 16'(bus.result), 16'd0);
    check("async_rst_vld", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    check("rst_hold_res", 16'(bus.result), 16'd0);
    check("rst_hold_vld", 16'(bus.out_valid), 16'd0);
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 4'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle_res", 16'(bus.result), 16'd0);
      check("idle_vld", 16'(bus.out_valid), 16'd0);
    end

    drive(1'b1, 4'd5, 4'd2);
    @(negedge clk);
    check("mul_5x2", 16'(bus.result), 16'd10);
    check("vld_5x2", 16'(bus.out_valid), 16'd1);
    drive(1'b1, 4'd2, 4'd3);
    @(negedge clk);
    check("mul_2x3", 16'(bus.result), 16'd6);
    check("vld_2x3", 16'(bus.out_valid), 16'd1);
    drive(1'b1, 4'd5, 4'd7);
    @(negedge clk);
    check("mul_5x7", 16'(bus.result), 16'd35);
    check("vld_5x7", 16'(bus.out_valid), 16'd1);
    drive(1'b1, 4'd0, 4'd9);
    @(negedge clk);
    check("mul_0x9", 16'(bus.result), 16'd0);
    drive(1'b1, 4'd1, 4'd13);
    @(negedge clk);
    check("mul_1x13", 16'(bus.result), 16'd13);
    drive(1'b1, 4'd15, 4'd15);
    @(negedge clk);
    check("mul_15x15", 16'(bus.result), 16'hE1);
    drive(1'b1, 4'd3, 4'd4);
    @(negedge clk);
    check("mul_3x4", 16'(bus.result), 16'd12);

    drive(1'b0, 4'd15, 4'd15);
    @(negedge clk);
    check("hold_res", 16'(bus.result), 16'd12);
    check("hold_vld", 16'(bus.out_valid), 16'd0);
    bus.a = 'x;
    bus.b = 'x;
    @(negedge clk);
    check("hold_x_res", 16'(bus.result), 16'd12);
    check("hold_x_vld", 16'(bus.out_valid), 16'd0);

    // Reset lands before the edge that would capture 6*7.
    drive(1'b1, 4'd6, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    check("flight_async_res", 16'(bus.result), 16'd0);
    check("flight_async_vld", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    check("flight_rst_res", 16'(bus.result), 16'd0);
    check("flight_rst_vld", 16'(bus.out_valid), 16'd0);
    rst_n = 1'b1;
    drive(1'b0, 4'd6, 4'd7);
    @(negedge clk);
    check("flight_rel_res", 16'(bus.result), 16'd0);
    check("flight_rel_vld", 16'(bus.out_valid), 16'd0);
    drive(1'b1, 4'd2, 4'd9);
    @(negedge clk);
    check("first_after_rst_res", 16'(bus.result), 16'd18);
    check("first_after_rst_vld", 16'(bus.out_valid), 16'd1);
    drive(1'b0, 4'd0, 4'd0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("exh_res_%0d", n_checks), 16'(bus.result), 16'(e));
          check("exh_vld", 16'(bus.out_valid), 16'd1);
        end
        drive(1'b1, 4'(x), 4'(y));
        exp_q.push_back(8'(x * y));
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check("exh_last_res", 16'(bus.result), 16'(e));
    check("exh_last_vld", 16'(bus.out_valid), 16'd1);
    drive(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    check("exh_end_vld", 16'(bus.out_valid), 16'd0);
    check("exh_end_res", 16'(bus.result), 16'd225);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_mul.md
Name: matrix_mul

Overview:
- Unsigned 4x4-bit multiplier producing an 8-bit product.
- Built as a partial-product matrix (AND array), reduced by a carry-save adder array, then a final ripple-carry adder.
- Product is registered on the output, so there is one cycle of latency.
- Used as the small arithmetic leaf in the ML datapath wherever a narrow operand product is needed.

Parameters:
- WIDTH, 4, operand width in bits. Result width is 2*WIDTH. Default behaviour is defined for 4; the RTL must stay generic for any WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b in the current cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  result holds a new product.
- result  output  2*WIDTH  registered unsigned product a*b.

Behaviour:
- Reset:
  - rst_n low forces result=0 and out_valid=0 immediately, with no clock needed.
  - Both outputs stay 0 while rst_n is low.
  - Release is synchronous to the next clk edge, handled by the usual reset synchroniser outside this block.
- Partial products: pp[i][j] = a[j] & b[i] for i,j in 0..WIDTH-1. Row i is weighted by 2^i.
- Reduction:
  - Rows are summed with a carry-save array of full/half adders.
  - A final ripple-carry adder resolves the sum and carry vectors to 2*WIDTH bits.
  - All of this is combinational between the input ports and the output register.
- Latency and throughput:
  - On each rising clk edge with in_valid=1: result <= a*b and out_valid <= 1.
  - On each rising clk edge with in_valid=0: out_valid <= 0 and result holds its previous value.
  - Latency is exactly 1 cycle. Throughput is one product per cycle, so back-to-back valid inputs are accepted every cycle.
- Handshake: none beyond in_valid. There is no backpressure and no ready signal.
- Width rules:
  - Fully unsigned. The product fits exactly in 2*WIDTH bits; the maximum is (2^WIDTH-1)^2 = 225 for WIDTH=4.
  - No overflow, truncation or saturation is possible.
- Boundaries:
  - Either operand 0 gives result 0.
  - Operand 1 passes the other operand through.
  - All-ones operands give 225 with no carry out of bit 7.
- Reset mid-operation:
  - Asserting rst_n while in_valid=1 discards the product in flight.
  - The first valid input accepted after reset release produces out_valid one cycle later.
- Inputs with in_valid=0 must never change result.
- No X on the outputs after reset, even if a or b is X while in_valid=0. The output register's enable is in_valid.

Decomposition:
- Shared package matrix_mul_pkg:
  - localparam MM_WIDTH = 4.
  - Function or localparam for the result width (2*MM_WIDTH).
  - Typedefs operand_t (logic [MM_WIDTH-1:0]) and product_t (logic [2*MM_WIDTH-1:0]).
- One natural sub-module, mm_full_adder (a, b, cin -> s, cout). It is instantiated in generate loops for both the carry-save array and the final ripple adder.
- Half-adder positions use mm_full_adder with cin tied to 0.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> result=0 and out_valid=0 immediately. Release, then drive in_valid=0 for 3 cycles -> outputs stay 0.
- Basic products: a=5,b=2, then a=2,b=3, then a=5,b=7 on consecutive cycles with in_valid=1 -> result 10, 6, 35 on the three following cycles, out_valid=1 throughout.
- Extremes: a=0,b=9 -> 0. a=1,b=13 -> 13. a=15,b=15 -> 225 (8'hE1).
- Hold: after a=3,b=4 (result 12), drive in_valid=0 with a=15,b=15 -> result stays 12, out_valid=0.
- Reset in flight: apply a=6,b=7 with in_valid=1, and assert rst_n low before the edge -> result=0, out_valid=0, and no 42 ever appears.
- Exhaustive: all 256 (a,b) pairs streamed back-to-back -> every result equals a*b exactly one cycle later.
